// File: rtl/gfx_pkg.sv
// Shared graphics definitions for the video pipeline.
//   COLOR_W        : default RRRGGGBB pixel width
//   game_state_e   : game-state encodings used by the controller
//   BLACK / WHITE  : colour constants
//   WIN_*_OFS      : winner-code offsets above the last sprite layer index
//   winner_code()  : builds a winner code from a layer count and an offset
package gfx_pkg;

  localparam int unsigned COLOR_W = 8;

  typedef enum logic [1:0] {
    MENU      = 2'd0,
    COUNTDOWN = 2'd1,
    GAMEPLAY  = 2'd2,
    GAME_OVER = 2'd3
  } game_state_e;

  localparam logic [COLOR_W-1:0] BLACK = '0;
  localparam logic [COLOR_W-1:0] WHITE = '1;

  // Winner codes: 0..NUM_LAYERS-1 are sprite layers, then background, then overlay.
  localparam int unsigned WIN_BG_OFS  = 0;
  localparam int unsigned WIN_OVL_OFS = 1;

  function automatic int unsigned winner_code(input int unsigned num_layers,
                                              input int unsigned ofs);
    return num_layers + ofs;
  endfunction

endpackage

// File: rtl/flash_timer.sv
// Single-layer hit-flash frame counter.
//   clk, rst     : pixel clock, asynchronous active-high reset
//   trigger      : one-cycle pulse that (re)loads the counter with FLASH_FRAMES
//   frame_start  : one-cycle pulse per frame; decrements a non-zero counter
//   active       : registered flag, high while the counter is non-zero
module flash_timer
#(
  parameter  int unsigned FLASH_FRAMES = 30,
  localparam int unsigned CNT_W        = $clog2(FLASH_FRAMES + 1)
)(
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  input  logic frame_start,
  output logic active
);

  import gfx_pkg::*;

  logic [CNT_W-1:0] cnt;

  // active tracks (cnt != 0) but is held in its own flop so the output is
  // driven straight from a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (trigger) begin
      cnt    <= CNT_W'(FLASH_FRAMES);
      active <= (FLASH_FRAMES != 0);
    end else if (frame_start && (cnt != '0)) begin
      cnt    <= cnt - CNT_W'(1);
      active <= (cnt != CNT_W'(1));
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: background, NUM_LAYERS prioritised sprite
// layers (layer 0 highest) and a menu overlay, with colour-key transparency,
// per-layer enable masks and frame-timed hit-flash/blink.
//   clk, rst             : pixel clock, asynchronous active-high reset
//   display_enable       : VGA DE for the current pixel
//   frame_start          : one pulse per frame, in blanking
//   background_color_in  : background pixel
//   layer_color_in       : packed layer colours, layer i at [i*COLOR_W +: COLOR_W]
//   layer_visible_in     : per-layer pixel coverage
//   layer_enable_in      : per-layer mask from the game state
//   key_color_in         : transparency key
//   overlay_color_in     : menu/countdown colour
//   overlay_visible_in   : menu pixel present
//   flash_trigger_in     : per-layer pulse that starts/restarts a flash
//   pixel_color_out      : final colour (2 clocks after inputs)
//   pixel_valid_out      : display_enable aligned with pixel_color_out
//   winner_layer_out     : source code of pixel_color_out
//   flash_active_out     : per-layer flash counter non-zero
module layer_compositor
#(
  parameter  int unsigned               NUM_LAYERS   = 4,
  parameter  int unsigned               COLOR_W      = gfx_pkg::COLOR_W,
  parameter  bit                        KEY_EN       = 1'b1,
  parameter  int unsigned               FLASH_FRAMES = 30,
  parameter  int unsigned               BLINK_PERIOD = 4,
  parameter  logic [COLOR_W-1:0]        FLASH_COLOR  = COLOR_W'(8'hFF),
  localparam int unsigned               LW           = $clog2(NUM_LAYERS + 2)
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          display_enable,
  input  logic                          frame_start,
  input  logic [COLOR_W-1:0]            background_color_in,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color_in,
  input  logic [NUM_LAYERS-1:0]         layer_visible_in,
  input  logic [NUM_LAYERS-1:0]         layer_enable_in,
  input  logic [COLOR_W-1:0]            key_color_in,
  input  logic [COLOR_W-1:0]            overlay_color_in,
  input  logic                          overlay_visible_in,
  input  logic [NUM_LAYERS-1:0]         flash_trigger_in,
  output logic [COLOR_W-1:0]            pixel_color_out,
  output logic                          pixel_valid_out,
  output logic [LW-1:0]                 winner_layer_out,
  output logic [NUM_LAYERS-1:0]         flash_active_out
);

  import gfx_pkg::*;

  localparam logic [LW-1:0] WIN_BG  = LW'(winner_code(NUM_LAYERS, WIN_BG_OFS));
  localparam logic [LW-1:0] WIN_OVL = LW'(winner_code(NUM_LAYERS, WIN_OVL_OFS));
  localparam int unsigned   BLINK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD - 1);

  // ---------------------------------------------------------------- flash
  logic [NUM_LAYERS-1:0] flash_active;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_flash
    flash_timer #(
      .FLASH_FRAMES(FLASH_FRAMES)
    ) u_flash (
      .clk        (clk),
      .rst        (rst),
      .trigger    (flash_trigger_in[g]),
      .frame_start(frame_start),
      .active     (flash_active[g])
    );
  end

  assign flash_active_out = flash_active;

  // Blink phase is shared by all layers; it idles at "on" so that every new
  // flash begins on the flash colour.
  logic               any_flash;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;

  assign any_flash = |flash_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!any_flash) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // -------------------------------------------------------------- stage 1
  logic [COLOR_W-1:0]    layer_color [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] eff;
  logic                  hit_c;
  logic [LW-1:0]         idx_c;
  logic [COLOR_W-1:0]    color_c;

  always_comb begin
    eff     = '0;
    hit_c   = 1'b0;
    idx_c   = '0;
    color_c = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      layer_color[i] = layer_color_in[i*COLOR_W +: COLOR_W];
      eff[i] = layer_visible_in[i] & layer_enable_in[i] &
               !(KEY_EN && (layer_color[i] == key_color_in));
    end
    // Ascending scan with a found flag: the first set bit is the winner.
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (eff[i] && !hit_c) begin
        hit_c   = 1'b1;
        idx_c   = LW'(i);
        color_c = layer_color[i];
      end
    end
  end

  logic               s1_hit;
  logic [LW-1:0]      s1_idx;
  logic [COLOR_W-1:0] s1_color;
  logic [COLOR_W-1:0] s1_bg;
  logic [COLOR_W-1:0] s1_ovl_color;
  logic               s1_ovl_vis;
  logic               s1_de;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hit       <= 1'b0;
      s1_idx       <= '0;
      s1_color     <= '0;
      s1_bg        <= '0;
      s1_ovl_color <= '0;
      s1_ovl_vis   <= 1'b0;
      s1_de        <= 1'b0;
    end else begin
      s1_hit       <= hit_c;
      s1_idx       <= idx_c;
      s1_color     <= color_c;
      s1_bg        <= background_color_in;
      s1_ovl_color <= overlay_color_in;
      s1_ovl_vis   <= overlay_visible_in;
      s1_de        <= display_enable;
    end
  end

  // -------------------------------------------------------------- stage 2
  logic               flash_sel;
  logic [COLOR_W-1:0] pix_d;
  logic [LW-1:0]      win_d;

  always_comb begin
    flash_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (s1_idx == LW'(i)) flash_sel = flash_active[i];
    end

    pix_d = s1_bg;
    win_d = WIN_BG;
    if (!s1_de) begin
      pix_d = '0;
      win_d = WIN_BG;
    end else if (s1_ovl_vis) begin
      pix_d = s1_ovl_color;
      win_d = WIN_OVL;
    end else if (s1_hit) begin
      pix_d = (flash_sel && blink_on) ? FLASH_COLOR : s1_color;
      win_d = s1_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_color_out  <= '0;
      pixel_valid_out  <= 1'b0;
      winner_layer_out <= WIN_BG;
    end else begin
      pixel_color_out  <= pix_d;
      pixel_valid_out  <= s1_de;
      winner_layer_out <= win_d;
    end
  end

endmodule
